switch_debounce: RTL and testbench



---
 rtl/switch_debounce_pkg.sv | 14 +
 rtl/switch_debounce_if.sv | 14 +
 rtl/switch_debounce_ch.sv | 71 +++++++
 rtl/switch_debounce.sv | 54 +++++
 tb/tb_switch_debounce.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/switch_debounce_pkg.sv
// Shared constants and helpers for the switch debounce block.
package sw_pkg;

  localparam int DEBOUNCE_DEF = 50000;
  localparam int DEBOUNCE_SIM = 8;

  // Counter width able to hold DEBOUNCE_CYCLES-1; never less than one bit.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/switch_debounce_if.sv
// Pin-side / consumer-side signal bundle of the switch debouncer.
interface switch_debounce_if #(
  parameter int N_CH = 4
);
  logic [N_CH-1:0] sw_raw;
  logic [N_CH-1:0] level;
  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] fall;
  logic [N_CH-1:0] toggle;
  logic            any_change;

  modport master (output sw_raw, input level, rise, fall, toggle, any_change);
  modport slave  (input sw_raw, output level, rise, fall, toggle, any_change);
endinterface

// File: rtl/switch_debounce_ch.sv
// One debounce channel: 2-flop synchroniser, stability counter, level and edge pulses.
module debounce_ch
  import sw_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_s_in,
  output logic o_level,
  output logic o_rise,
  output logic o_fall,
  output logic o_toggle,
  output logic o_commit
);

  if (DEBOUNCE_CYCLES < 1 || longint'(DEBOUNCE_CYCLES) > (longint'(1) << CNT_W)) begin : g_bad_param
    $error("debounce_ch: DEBOUNCE_CYCLES=%0d outside 1..2**CNT_W (CNT_W=%0d)",
           DEBOUNCE_CYCLES, CNT_W);
  end

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_rise;
  logic             r_fall;
  logic             r_toggle;
  logic [CNT_W-1:0] r_cnt;
  logic             w_diff;

  assign w_diff   = r_sync2 != r_level;
  assign o_commit = w_diff && (r_cnt == LAST);

  // Counter saturates at LAST by construction: it is cleared whenever it reaches it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_level  <= 1'b0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
      r_toggle <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= i_s_in;
      r_sync2 <= r_sync1;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
        r_rise  <= r_sync2;
        r_fall  <= ~r_sync2;
        if (r_sync2) r_toggle <= ~r_toggle;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level  = r_level;
  assign o_rise   = r_rise;
  assign o_fall   = r_fall;
  assign o_toggle = r_toggle;

endmodule

// File: rtl/switch_debounce.sv
// Debounces N_CH raw switch pins into clean levels plus rise/fall/toggle events.
module switch_debounce
  import sw_pkg::*;
#(
  parameter int N_CH            = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter int CNT_W           = 16,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  switch_debounce_if.slave   bus
);

  logic [N_CH-1:0] w_s_in;
  logic [N_CH-1:0] w_level;
  logic [N_CH-1:0] w_rise;
  logic [N_CH-1:0] w_fall;
  logic [N_CH-1:0] w_toggle;
  logic [N_CH-1:0] w_commit;
  logic            r_any_change;

  // Polarity is fixed before the synchroniser so every channel sees 1 = active.
  assign w_s_in = ACTIVE_LOW ? ~bus.sw_raw : bus.sw_raw;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .i_s_in   (w_s_in[g]),
      .o_level  (w_level[g]),
      .o_rise   (w_rise[g]),
      .o_fall   (w_fall[g]),
      .o_toggle (w_toggle[g]),
      .o_commit (w_commit[g])
    );
  end

  // Registered from the channels' commit strobes so it lines up with rise/fall.
  always_ff @(posedge clk) begin
    if (reset) r_any_change <= 1'b0;
    else       r_any_change <= |w_commit;
  end

  assign bus.level      = w_level;
  assign bus.rise       = w_rise;
  assign bus.fall       = w_fall;
  assign bus.toggle     = w_toggle;
  assign bus.any_change = r_any_change;

endmodule

// File: tb/tb_switch_debounce.sv
// Scoreboard bench for switch_debounce with a short debounce window.
module tb_switch_debounce;
  import sw_pkg::*;

  localparam int N_CH = 4;
  localparam int DB   = DEBOUNCE_SIM;
  localparam int LAT  = DB + 2;

  typedef struct {
    int         cyc;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] level;
    logic [3:0] toggle;
  } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   ecnt = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  ev_t  sbq[$];
  ev_t  mon_e;
  logic [3:0] cur_sw;
  logic [3:0] exp_level = 4'h0;
  logic [3:0] exp_tog = 4'h0;

  switch_debounce_if #(.N_CH(N_CH)) ifc ();

  switch_debounce #(
    .N_CH            (N_CH),
    .DEBOUNCE_CYCLES (DB),
    .CNT_W           (cnt_width(DB)),
    .ACTIVE_LOW      (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ecnt <= ecnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, ecnt);
    end
  endtask

  task automatic drive(input logic [3:0] v);
    @(negedge clk);
    cur_sw = v;
    ifc.sw_raw = v;
  endtask

  // Expected event LAT edges after the pin change just driven.
  task automatic expect_ev(input logic [3:0] r, input logic [3:0] f);
    ev_t e;
    exp_level = (exp_level | r) & ~f;
    exp_tog   = exp_tog ^ r;
    e.cyc = ecnt + LAT;
    e.rise = r;
    e.fall = f;
    e.level = exp_level;
    e.toggle = exp_tog;
    sbq.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (sbq.size() > 0 && sbq[0].cyc < ecnt) begin
        check("missed_event_cycle", 32'(ecnt), 32'(sbq[0].cyc));
        void'(sbq.pop_front());
      end
      if ((ifc.rise | ifc.fall) !== 4'h0 || ifc.any_change !== 1'b0) begin
        if (sbq.size() == 0) begin
          check("unexpected_pulse", {23'd0, ifc.any_change, ifc.rise, ifc.fall}, 32'd0);
        end else begin
          mon_e = sbq.pop_front();
          check("event_cycle", 32'(ecnt), 32'(mon_e.cyc));
          check("event_rise", 32'(ifc.rise), 32'(mon_e.rise));
          check("event_fall", 32'(ifc.fall), 32'(mon_e.fall));
          check("event_level", 32'(ifc.level), 32'(mon_e.level));
          check("event_toggle", 32'(ifc.toggle), 32'(mon_e.toggle));
          check("event_any_change", 32'(ifc.any_change), 32'd1);
        end
      end
    end
  end

  initial begin
    cur_sw = 4'hF;
    ifc.sw_raw = 4'hF;
    reset = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    idle(2);
    check("reset_level", 32'(ifc.level), 32'd0);
    check("reset_toggle", 32'(ifc.toggle), 32'd0);
    check("reset_pulses", {24'd0, ifc.rise, ifc.fall}, 32'd0);
    check("reset_any_change", 32'(ifc.any_change), 32'd0);
    reset = 1'b0;
    idle(12);
    check("idle_level", 32'(ifc.level), 32'd0);

    // Clean press on channel 0, with an explicit one-edge-early look.
    drive(4'hE);
    expect_ev(4'h1, 4'h0);
    idle(LAT - 1);
    check("press_level_early", 32'(ifc.level[0]), 32'd0);
    idle(1);
    check("press_level_on_time", 32'(ifc.level[0]), 32'd1);
    idle(4);
    check("press_toggle_held", 32'(ifc.toggle), 32'h1);

    // Bouncing channel 1: short low runs must be ignored.
    drive(4'hC); idle(4);
    drive(4'hE);
    drive(4'hC); idle(2);
    drive(4'hE);
    idle(12);
    check("bounce_level", 32'(ifc.level), 32'h1);
    drive(4'hC);
    expect_ev(4'h2, 4'h0);
    idle(14);

    // Release channel 0: fall, toggle unchanged.
    drive(4'hD);
    expect_ev(4'h0, 4'h1);
    idle(14);
    check("release_toggle", 32'(ifc.toggle), 32'h3);

    // All inactive, then every channel at once, then all released.
    drive(4'hF);
    expect_ev(4'h0, 4'h2);
    idle(14);
    drive(4'h0);
    expect_ev(4'hF, 4'h0);
    idle(14);
    check("simul_level", 32'(ifc.level), 32'hF);
    drive(4'hF);
    expect_ev(4'h0, 4'hF);
    idle(14);

    // Reset in the middle of channel 2's count.
    drive(4'hB);
    idle(7);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset_level", 32'(ifc.level), 32'd0);
    exp_level = 4'h0;
    exp_tog = 4'h0;
    expect_ev(4'h4, 4'h0);
    idle(LAT + 4);
    check("midreset_final_level", 32'(ifc.level), 32'h4);

    check("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
